vram_arbiter: RTL and testbench

- Shares one single-port synchronous screen RAM between the video fetch engine (bitmap/attribute reads) and the CPU (reads/writes to the screen pages).
- Video reads have absolute priority and a fixed latency, so pixel timing never slips.
- CPU accesses use a one-entry request buffer with a req/ack handshake and issue in free RAM cycles.
- Sits between the video controller / memory decoder and the VRAM macro, in the clk_sys domain.

---
 rtl/vram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares one single-port synchronous screen RAM between the video fetch engine
// and the CPU. Video reads always win the issue slot and have a fixed latency
// of RAM_LAT+2 cycles. CPU accesses are captured into a one-entry buffer and
// issued on the first cycle without a video read.
//
// Ports
//   clk_sys, nRESET            clock, asynchronous active-low reset
//   vid_rd, vid_addr           video read strobe and address
//   vid_dout, vid_valid        video read data and its one-cycle strobe
//   cpu_req, cpu_we,           CPU request (level, held until cpu_ack),
//   cpu_addr, cpu_din          direction, address and write data
//   cpu_dout, cpu_ack          CPU read data and completion strobe
//   cpu_wait                   captured CPU op waiting for a free slot
//   starve                     sticky: a CPU op waited MAX_WAIT cycles
//   ram_addr, ram_din, ram_we  registered RAM command
//   ram_dout                   RAM read data, RAM_LAT cycles after ram_addr
// -----------------------------------------------------------------------------
module vram_arbiter #(
   parameter int AW       = 15,
   parameter int DW       = 8,
   parameter int RAM_LAT  = 1,
   parameter int MAX_WAIT = 32
) (
   input  logic          clk_sys,
   input  logic          nRESET,
   input  logic          vid_rd,
   input  logic [AW-1:0] vid_addr,
   output logic [DW-1:0] vid_dout,
   output logic          vid_valid,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_din,
   output logic [DW-1:0] cpu_dout,
   output logic          cpu_ack,
   output logic          cpu_wait,
   output logic          starve,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_we,
   input  logic [DW-1:0] ram_dout
);

   localparam int             CW      = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_WAIT);

   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,
      ST_PENDING  = 2'd1,
      ST_INFLIGHT = 2'd2
   } buf_state_t;

   buf_state_t    state_q, state_d;
   logic          buf_we_q, buf_we_d;
   logic [AW-1:0] buf_addr_q, buf_addr_d;
   logic [DW-1:0] buf_din_q, buf_din_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          starve_q, starve_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [DW-1:0] ram_din_q, ram_din_d;
   logic          ram_we_q, ram_we_d;
   logic          vid_valid_q, vid_valid_d;
   logic [DW-1:0] vid_dout_q, vid_dout_d;
   logic          cpu_ack_q, cpu_ack_d;
   logic [DW-1:0] cpu_dout_q, cpu_dout_d;

   // Tag pipe: bit 1 = video read, bit 0 = CPU read. Stage 0 lines up with
   // ram_addr; stage RAM_LAT lines up with the matching ram_dout.
   logic [RAM_LAT:0][1:0] tag_q, tag_d;

   logic cpu_issue;
   logic cpu_rd_done;

   always_comb begin
      state_d    = state_q;
      buf_we_d   = buf_we_q;
      buf_addr_d = buf_addr_q;
      buf_din_d  = buf_din_q;
      wait_cnt_d = wait_cnt_q;
      starve_d   = starve_q;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      ram_we_d   = 1'b0;
      tag_d      = tag_q;

      // The CPU only gets the slot when video does not want it.
      cpu_issue = (state_q == ST_PENDING) && !vid_rd;

      // Issue slot
      if (vid_rd) begin
         ram_addr_d = vid_addr;
      end else if (cpu_issue) begin
         ram_addr_d = buf_addr_q;
         ram_we_d   = buf_we_q;
         if (buf_we_q) begin
            ram_din_d = buf_din_q;
         end
      end

      tag_d[0] = {vid_rd, cpu_issue & ~buf_we_q};
      for (int i = 1; i <= RAM_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end

      // Request buffer
      case (state_q)
         ST_EMPTY: begin
            if (cpu_req) begin
               buf_we_d   = cpu_we;
               buf_addr_d = cpu_addr;
               buf_din_d  = cpu_din;
               state_d    = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (cpu_issue) begin
               state_d = ST_INFLIGHT;
            end
         end
         ST_INFLIGHT: begin
            // Leaving on the ack cycle itself means a request seen during
            // that cycle is ignored; capture starts the cycle after.
            if (cpu_ack_q) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Starvation counter counts PENDING cycles that lost the slot.
      if (state_q == ST_PENDING) begin
         if (cpu_issue) begin
            wait_cnt_d = '0;
         end else if (wait_cnt_q != MAX_CNT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
      end
      if (wait_cnt_d == MAX_CNT) begin
         starve_d = 1'b1;
      end

      // Result steering at the pipe exit
      cpu_rd_done = tag_q[RAM_LAT][0];
      vid_valid_d = tag_q[RAM_LAT][1];
      vid_dout_d  = vid_valid_d ? ram_dout : vid_dout_q;
      cpu_dout_d  = cpu_rd_done ? ram_dout : cpu_dout_q;
      // Only CPU ops ever write, so a write ack follows ram_we directly.
      cpu_ack_d   = cpu_rd_done | ram_we_q;
   end

   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         state_q     <= ST_EMPTY;
         buf_we_q    <= 1'b0;
         buf_addr_q  <= '0;
         buf_din_q   <= '0;
         wait_cnt_q  <= '0;
         starve_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
         ram_we_q    <= 1'b0;
         tag_q       <= '0;
         vid_valid_q <= 1'b0;
         vid_dout_q  <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_dout_q  <= '0;
      end else begin
         state_q     <= state_d;
         buf_we_q    <= buf_we_d;
         buf_addr_q  <= buf_addr_d;
         buf_din_q   <= buf_din_d;
         wait_cnt_q  <= wait_cnt_d;
         starve_q    <= starve_d;
         ram_addr_q  <= ram_addr_d;
         ram_din_q   <= ram_din_d;
         ram_we_q    <= ram_we_d;
         tag_q       <= tag_d;
         vid_valid_q <= vid_valid_d;
         vid_dout_q  <= vid_dout_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_dout_q  <= cpu_dout_d;
      end
   end

   assign vid_dout  = vid_dout_q;
   assign vid_valid = vid_valid_q;
   assign cpu_dout  = cpu_dout_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_wait  = (state_q == ST_PENDING);
   assign starve    = starve_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;
   assign ram_we    = ram_we_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Directed bench for vram_arbiter with a behavioural single-port RAM
// (read latency 1). Inputs are driven 1 time unit after the rising edge;
// outputs are sampled on the falling edge. Cycle k is the interval that
// starts at rising edge number k.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

   localparam int AW = 15;
   localparam int DW = 8;

   logic          clk_sys = 1'b0;
   logic          nRESET;
   logic          vid_rd;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_dout;
   logic          vid_valid;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_din;
   logic [DW-1:0] cpu_dout;
   logic          cpu_ack;
   logic          cpu_wait;
   logic          starve;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   logic [DW-1:0] ram_dout;

   vram_arbiter #(.AW(AW), .DW(DW), .RAM_LAT(1), .MAX_WAIT(32)) dut (
      .clk_sys  (clk_sys),
      .nRESET   (nRESET),
      .vid_rd   (vid_rd),
      .vid_addr (vid_addr),
      .vid_dout (vid_dout),
      .vid_valid(vid_valid),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_din  (cpu_din),
      .cpu_dout (cpu_dout),
      .cpu_ack  (cpu_ack),
      .cpu_wait (cpu_wait),
      .starve   (starve),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_we   (ram_we),
      .ram_dout (ram_dout)
   );

   always #5 clk_sys = ~clk_sys;

   // Behavioural screen RAM, one cycle read latency
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk_sys) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   // Event logs
   int            vv_cyc[$];
   logic [DW-1:0] vv_dat[$];
   int            ack_cyc_q[$];
   int            we_cyc[$];
   logic [AW-1:0] we_addr[$];
   logic [DW-1:0] we_din[$];

   always @(negedge clk_sys) begin
      if (vid_valid) begin
         vv_cyc.push_back(cyc);
         vv_dat.push_back(vid_dout);
      end
      if (cpu_ack) ack_cyc_q.push_back(cyc);
      if (ram_we) begin
         we_cyc.push_back(cyc);
         we_addr.push_back(ram_addr);
         we_din.push_back(ram_din);
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic clear_logs();
      vv_cyc.delete();
      vv_dat.delete();
      ack_cyc_q.delete();
      we_cyc.delete();
      we_addr.delete();
      we_din.delete();
   endtask

   task automatic cpu_start(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int c);
      @(posedge clk_sys); #1;
      cpu_req  = 1'b1;
      cpu_we   = we;
      cpu_addr = a;
      cpu_din  = d;
      c = cyc;
   endtask

   // Bounded wait for cpu_ack; drops cpu_req in the cycle after the ack.
   task automatic wait_ack(output int a_cyc, output logic [DW-1:0] d);
      bit seen = 0;
      a_cyc = -1;
      d = '0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk_sys);
         if (cpu_ack) begin
            seen  = 1;
            a_cyc = cyc;
            d     = cpu_dout;
         end
      end
      chk("ack_seen", 32'(seen), 32'd1);
      @(posedge clk_sys); #1;
      cpu_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            c0, a;
      int            wcnt;
      logic [DW-1:0] d;
      logic          st32, st33, st39, w39;

      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      nRESET = 1'b0; vid_rd = 0; vid_addr = '0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;

      // Reset state
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      chk("rst_vid_valid", 32'(vid_valid), 0);
      chk("rst_cpu_ack", 32'(cpu_ack), 0);
      chk("rst_cpu_wait", 32'(cpu_wait), 0);
      chk("rst_starve", 32'(starve), 0);
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      @(posedge clk_sys); #1;
      nRESET = 1'b1;
      repeat (2) @(posedge clk_sys);

      // 1. Video reads
      mem[15'h1800] = 8'hA5;
      for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + 8'(i) * 8'h11);
      clear_logs();
      @(posedge clk_sys); #1;
      vid_rd = 1; vid_addr = 15'h1800; c0 = cyc;
      @(posedge clk_sys); #1;
      vid_rd = 0;
      repeat (5) @(posedge clk_sys);
      chk("v1_count", 32'(vv_cyc.size()), 1);
      chk("v1_lat", (vv_cyc.size() > 0) ? 32'(vv_cyc[0] - c0) : 32'hFFFF_FFFF, 3);
      chk("v1_data", (vv_dat.size() > 0) ? 32'(vv_dat[0]) : 32'hFFFF_FFFF, 32'hA5);

      clear_logs();
      for (int i = 0; i < 8; i++) begin
         @(posedge clk_sys); #1;
         if (i == 0) c0 = cyc;
         vid_rd = 1; vid_addr = 15'(i);
      end
      @(posedge clk_sys); #1;
      vid_rd = 0;
      repeat (5) @(posedge clk_sys);
      chk("v8_count", 32'(vv_cyc.size()), 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("v8_cyc%0d", i), (vv_cyc.size() > i) ? 32'(vv_cyc[i] - c0) : 32'hFFFF_FFFF, 32'(3 + i));
         chk($sformatf("v8_dat%0d", i), (vv_dat.size() > i) ? 32'(vv_dat[i]) : 32'hFFFF_FFFF,
             32'(8'(8'h10 + 8'(i) * 8'h11)));
      end

      // 2. Idle CPU write then read
      clear_logs();
      cpu_start(1'b1, 15'h4000, 8'h3C, c0);
      wait_ack(a, d);
      chk("w_ack_lat", 32'(a - c0), 3);
      chk("w_we_count", 32'(we_cyc.size()), 1);
      chk("w_we_cyc", (we_cyc.size() > 0) ? 32'(we_cyc[0] - c0) : 32'hFFFF_FFFF, 2);
      chk("w_we_addr", (we_addr.size() > 0) ? 32'(we_addr[0]) : 32'hFFFF_FFFF, 32'h4000);
      chk("w_we_din", (we_din.size() > 0) ? 32'(we_din[0]) : 32'hFFFF_FFFF, 32'h3C);
      chk("w_cpu_dout_kept", 32'(cpu_dout), 0);

      clear_logs();
      cpu_start(1'b0, 15'h4000, 8'h00, c0);
      wait_ack(a, d);
      chk("r_ack_lat", 32'(a - c0), 4);
      chk("r_data", 32'(d), 32'h3C);
      chk("r_no_we", 32'(we_cyc.size()), 0);
      chk("r_ack_count", 32'(ack_cyc_q.size()), 1);

      // 3. Contention with a 10-cycle video burst
      mem[15'h0010] = 8'h5A;
      for (int i = 0; i < 10; i++) mem[15'h20 + i] = 8'(8'h80 + i);
      clear_logs();
      wcnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk_sys); #1;
         if (i == 0) c0 = cyc;
         vid_rd = 1; vid_addr = 15'(15'h20 + i);
         if (i == 2) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0010; cpu_din = '0;
         end
         @(negedge clk_sys);
         if (i >= 3 && cpu_wait) wcnt++;
      end
      @(posedge clk_sys); #1;
      vid_rd = 0;
      wait_ack(a, d);
      chk("c_wait_cycles", 32'(wcnt), 7);
      chk("c_ack_lat", 32'(a - c0), 13);
      chk("c_data", 32'(d), 32'h5A);
      chk("c_wait_after", 32'(cpu_wait), 0);
      chk("c_vid_count", 32'(vv_cyc.size()), 10);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("c_vcyc%0d", i), (vv_cyc.size() > i) ? 32'(vv_cyc[i] - c0) : 32'hFFFF_FFFF, 32'(3 + i));
         chk($sformatf("c_vdat%0d", i), (vv_dat.size() > i) ? 32'(vv_dat[i]) : 32'hFFFF_FFFF, 32'(8'h80 + i));
      end

      // 4. Starvation under 40 cycles of continuous video
      mem[15'h0011] = 8'h77;
      chk("s_starve_before", 32'(starve), 0);
      st32 = 0; st33 = 0; st39 = 0; w39 = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_sys); #1;
         if (i == 0) begin
            c0 = cyc;
            cpu_req = 1; cpu_we = 0; cpu_addr = 15'h0011;
         end
         vid_rd = 1; vid_addr = 15'(i);
         @(negedge clk_sys);
         if (i == 32) st32 = starve;
         if (i == 33) st33 = starve;
         if (i == 39) begin
            st39 = starve;
            w39  = cpu_wait;
         end
      end
      @(posedge clk_sys); #1;
      vid_rd = 0;
      wait_ack(a, d);
      chk("s_starve_at32", 32'(st32), 0);
      chk("s_starve_at33", 32'(st33), 1);
      chk("s_starve_at39", 32'(st39), 1);
      chk("s_wait_at39", 32'(w39), 1);
      chk("s_data", 32'(d), 32'h77);
      chk("s_ack_lat", 32'(a - c0), 43);
      chk("s_starve_sticky", 32'(starve), 1);

      // 5. Read/write ordering hazard on 0x0100
      mem[15'h0100] = 8'h11;
      clear_logs();
      @(posedge clk_sys); #1;
      c0 = cyc; vid_rd = 1; vid_addr = 15'h0100;
      @(posedge clk_sys); #1;
      vid_rd = 0;
      cpu_req = 1; cpu_we = 1; cpu_addr = 15'h0100; cpu_din = 8'h22;
      @(posedge clk_sys); #1;
      @(posedge clk_sys); #1;
      vid_rd = 1; vid_addr = 15'h0100;
      @(posedge clk_sys); #1;
      vid_rd = 0;
      wait_ack(a, d);
      repeat (4) @(posedge clk_sys);
      chk("h_ack_lat", 32'(a - c0), 4);
      chk("h_vid_count", 32'(vv_cyc.size()), 2);
      chk("h_old_data", (vv_dat.size() > 0) ? 32'(vv_dat[0]) : 32'hFFFF_FFFF, 32'h11);
      chk("h_new_data", (vv_dat.size() > 1) ? 32'(vv_dat[1]) : 32'hFFFF_FFFF, 32'h22);
      chk("h_new_cyc", (vv_cyc.size() > 1) ? 32'(vv_cyc[1] - c0) : 32'hFFFF_FFFF, 6);

      // 6. Reset while a CPU read is in flight
      mem[15'h0123] = 8'h44;
      cpu_start(1'b0, 15'h0123, 8'h00, c0);
      @(posedge clk_sys); #1;
      @(posedge clk_sys); #1;
      chk("x_ram_addr_pre", 32'(ram_addr), 32'h0123);
      nRESET = 1'b0;
      cpu_req = 1'b0;
      #1;
      clear_logs();
      chk("x_ram_addr", 32'(ram_addr), 0);
      chk("x_ram_din", 32'(ram_din), 0);
      chk("x_ram_we", 32'(ram_we), 0);
      chk("x_starve", 32'(starve), 0);
      chk("x_cpu_wait", 32'(cpu_wait), 0);
      chk("x_cpu_ack", 32'(cpu_ack), 0);
      chk("x_cpu_dout", 32'(cpu_dout), 0);
      chk("x_vid_valid", 32'(vid_valid), 0);
      chk("x_vid_dout", 32'(vid_dout), 0);
      repeat (2) @(posedge clk_sys);
      #1;
      nRESET = 1'b1;
      repeat (6) @(posedge clk_sys);
      chk("x_no_ack", 32'(ack_cyc_q.size()), 0);
      chk("x_no_vid", 32'(vv_cyc.size()), 0);
      cpu_start(1'b0, 15'h1800, 8'h00, c0);
      wait_ack(a, d);
      chk("x_post_lat", 32'(a - c0), 4);
      chk("x_post_data", 32'(d), 32'hA5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
